// File: rtl/secventiator_cursa_if.sv
// Signal bundle between the race sequencer, the motion logic, the sensors
// and the motor drivers.
interface secventiator_cursa_if;
  logic        senzor_1;
  logic        senzor_5;
  logic [1:0]  circuit;
  logic        start;
  logic [1:0]  directie_in_A;
  logic [1:0]  directie_in_B;
  logic [11:0] factor_dc_in_A;
  logic [11:0] factor_dc_in_B;
  logic [1:0]  directie_driverA;
  logic [1:0]  directie_driverB;
  logic [11:0] factor_dc_driverA;
  logic [11:0] factor_dc_driverB;
  logic [7:0]  count_ture;
  logic [1:0]  stare;
  logic        cursa_gata;
  logic        stop;

  // Sequencer side.
  modport slave (
    input  senzor_1, senzor_5, circuit, start,
           directie_in_A, directie_in_B, factor_dc_in_A, factor_dc_in_B,
    output directie_driverA, directie_driverB, factor_dc_driverA, factor_dc_driverB,
           count_ture, stare, cursa_gata, stop
  );

  // Environment side (sensors, mode selection, motion logic, drivers).
  modport master (
    output senzor_1, senzor_5, circuit, start,
           directie_in_A, directie_in_B, factor_dc_in_A, factor_dc_in_B,
    input  directie_driverA, directie_driverB, factor_dc_driverA, factor_dc_driverB,
           count_ture, stare, cursa_gata, stop
  );
endinterface

// File: rtl/secventiator_cursa.sv
// Race sequencer: debounces the finish line (both outer sensors on black),
// counts laps once per crossing, holds run/stop state and gates the motion
// logic's direction and PWM compare values onto the motor drivers.
module secventiator_cursa #(
  parameter int unsigned DEB_CYCLES   = 1000,
  parameter int unsigned BLANK_CYCLES = 5000,
  parameter int unsigned TURE_C2      = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  secventiator_cursa_if.slave  bus
);

  localparam int unsigned DEB_W   = (DEB_CYCLES > 1)   ? $clog2(DEB_CYCLES)   : 1;
  localparam int unsigned BLANK_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEB_CYCLES - 1);
  localparam logic [BLANK_W-1:0] BLANK_LAST = BLANK_W'(BLANK_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    LINIE = 2'b10,
    GATA  = 2'b11
  } state_t;

  state_t             state, state_nxt;
  logic [7:0]         ture, ture_nxt, ture_inc;
  logic [DEB_W-1:0]   deb_cnt, deb_nxt;
  logic [BLANK_W-1:0] blank_cnt, blank_nxt;
  logic               pair_hi, pair_lo, target_hit, motors_nxt;

  assign pair_hi  = bus.senzor_1 & bus.senzor_5;
  assign pair_lo  = ~bus.senzor_1 & ~bus.senzor_5;
  assign ture_inc = (ture == 8'hFF) ? 8'hFF : ture + 8'd1;

  // Lap target check on the post-increment count, using the mode seen on the crossing cycle.
  always_comb begin
    target_hit = 1'b0;
    case (bus.circuit)
      2'b01:   target_hit = 1'b1;
      2'b10:   target_hit = (32'(ture_inc) >= TURE_C2);
      default: target_hit = 1'b0;
    endcase
  end

  // Next-state and counter logic; circuit==00 overrides everything else.
  always_comb begin
    state_nxt = state;
    ture_nxt  = ture;
    deb_nxt   = deb_cnt;
    blank_nxt = blank_cnt;
    if (bus.circuit == 2'b00) begin
      state_nxt = IDLE;
      ture_nxt  = '0;
      deb_nxt   = '0;
      blank_nxt = '0;
    end else begin
      case (state)
        IDLE, GATA: begin
          if (bus.start) begin
            state_nxt = RUN;
            ture_nxt  = '0;
            deb_nxt   = '0;
            blank_nxt = '0;
          end
        end
        RUN: begin
          blank_nxt = '0;
          if (!pair_hi) begin
            deb_nxt = '0;
          end else if (deb_cnt == DEB_LAST) begin
            ture_nxt  = ture_inc;
            deb_nxt   = '0;
            state_nxt = target_hit ? GATA : LINIE;
          end else begin
            deb_nxt = deb_cnt + 1'b1;
          end
        end
        LINIE: begin
          if (!pair_lo) begin
            blank_nxt = '0;
          end else if (blank_cnt == BLANK_LAST) begin
            state_nxt = RUN;
            deb_nxt   = '0;
            blank_nxt = '0;
          end else begin
            blank_nxt = blank_cnt + 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
    motors_nxt = (state_nxt == RUN) || (state_nxt == LINIE);
  end

  // State, counters and outputs are registered together; gating follows the
  // next state so that reaching the target kills the drivers on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state                 <= IDLE;
      ture                  <= '0;
      deb_cnt               <= '0;
      blank_cnt             <= '0;
      bus.directie_driverA  <= '0;
      bus.directie_driverB  <= '0;
      bus.factor_dc_driverA <= '0;
      bus.factor_dc_driverB <= '0;
      bus.cursa_gata        <= 1'b0;
      bus.stop              <= 1'b1;
    end else begin
      state                 <= state_nxt;
      ture                  <= ture_nxt;
      deb_cnt               <= deb_nxt;
      blank_cnt             <= blank_nxt;
      bus.directie_driverA  <= motors_nxt ? bus.directie_in_A  : '0;
      bus.directie_driverB  <= motors_nxt ? bus.directie_in_B  : '0;
      bus.factor_dc_driverA <= motors_nxt ? bus.factor_dc_in_A : '0;
      bus.factor_dc_driverB <= motors_nxt ? bus.factor_dc_in_B : '0;
      bus.cursa_gata        <= (state_nxt == GATA);
      bus.stop              <= ~motors_nxt;
    end
  end

  assign bus.stare      = state;
  assign bus.count_ture = ture;

endmodule
